// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular add/subtract datapath: operation modes,
// default geometry and a lane-slice helper for packed multi-lane buses.
package mod_arith_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEF_BITWIDTH = 16;
  localparam int DEF_LANES    = 4;

  // Low bit index of a lane inside a packed multi-lane bus
  function automatic int laneLo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mod_lane_reduce.sv
// Single-lane final reduction: folds a BITWIDTH+1 bit raw sum/difference
// back into the range [0, Q).
module mod_lane_reduce
  import mod_arith_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] iRaw,
  input  logic                iBorrow,
  input  logic                iSub,
  input  logic [BITWIDTH-1:0] iQ,
  output logic [BITWIDTH-1:0] oRed
);

  // Add: conditional subtract of Q; subtract: add Q back on borrow
  always_comb begin
    oRed = {BITWIDTH{1'b0}};
    if (iSub == MODE_SUB) begin
      if (iBorrow) begin
        oRed = iRaw + iQ;
      end else begin
        oRed = iRaw;
      end
    end else begin
      if ({iBorrow, iRaw} < {1'b0, iQ}) begin
        oRed = iRaw;
      end else begin
        oRed = iRaw - iQ;
      end
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Multi-lane two-stage modular adder/subtractor with a stall-all valid/ready
// pipeline; the modulus and mode travel with each transaction.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int LANES    = DEF_LANES
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iClr,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic                      iSub,
  input  logic [LANES*BITWIDTH-1:0] iData0,
  input  logic [LANES*BITWIDTH-1:0] iData1,
  input  logic [BITWIDTH-1:0]       iQ,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [LANES*BITWIDTH-1:0] oData
);

  logic                               en_s;
  logic                               s1Valid_r;
  logic                               s1Sub_r;
  logic [BITWIDTH-1:0]                s1Q_r;
  logic [LANES-1:0][BITWIDTH:0]       rawNext_s;
  logic [LANES-1:0][BITWIDTH:0]       s1Raw_r;
  logic [LANES-1:0][BITWIDTH-1:0]     red_s;

  assign en_s   = ~oValid | iReady;
  assign oReady = en_s;

  // Stage-1 raw value per lane; the extra MSB is the carry (add) or borrow (sub)
  always_comb begin
    rawNext_s = {(LANES*(BITWIDTH+1)){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (iSub == MODE_SUB) begin
        rawNext_s[k] = {1'b0, iData0[laneLo(k, BITWIDTH) +: BITWIDTH]}
                     - {1'b0, iData1[laneLo(k, BITWIDTH) +: BITWIDTH]};
      end else begin
        rawNext_s[k] = {1'b0, iData0[laneLo(k, BITWIDTH) +: BITWIDTH]}
                     + {1'b0, iData1[laneLo(k, BITWIDTH) +: BITWIDTH]};
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : gLane
    mod_lane_reduce #(
      .BITWIDTH(BITWIDTH)
    ) uReduce (
      .iRaw   (s1Raw_r[k][BITWIDTH-1:0]),
      .iBorrow(s1Raw_r[k][BITWIDTH]),
      .iSub   (s1Sub_r),
      .iQ     (s1Q_r),
      .oRed   (red_s[k])
    );
  end

  // Pipeline registers: flush drops valids only, enable advances both stages
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1Valid_r <= 1'b0;
      s1Sub_r   <= 1'b0;
      s1Q_r     <= {BITWIDTH{1'b0}};
      s1Raw_r   <= {(LANES*(BITWIDTH+1)){1'b0}};
      oValid    <= 1'b0;
      oData     <= {(LANES*BITWIDTH){1'b0}};
    end else if (iClr) begin
      s1Valid_r <= 1'b0;
      oValid    <= 1'b0;
    end else if (en_s) begin
      s1Valid_r <= iValid;
      s1Sub_r   <= iSub;
      s1Q_r     <= iQ;
      s1Raw_r   <= rawNext_s;
      oValid    <= s1Valid_r;
      oData     <= red_s;
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe (BITWIDTH=8, LANES=4) using a
// queue-based arithmetic reference model.
module tb_mod_addsub_pipe;

  localparam int W = 8;
  localparam int L = 4;

  logic         iClk, iRst, iClr, iValid, oReady, iSub, oValid, iReady;
  logic [L*W-1:0] iData0, iData1, oData;
  logic [W-1:0]   iQ;

  int checks = 0;
  int failures = 0;

  logic [L*W-1:0] expQ[$];
  logic           obsValid, obsReady;
  logic [L*W-1:0] obsData;

  mod_addsub_pipe #(.BITWIDTH(W), .LANES(L)) dut (
    .iClk(iClk), .iRst(iRst), .iClr(iClr), .iValid(iValid), .oReady(oReady),
    .iSub(iSub), .iData0(iData0), .iData1(iData1), .iQ(iQ),
    .oValid(oValid), .iReady(iReady), .oData(oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [L*W-1:0] model(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                           input logic [W-1:0] q, input logic s);
    logic [L*W-1:0] r;
    int x, y, m, v;
    r = '0;
    for (int k = 0; k < L; k++) begin
      x = int'(a[k*W +: W]);
      y = int'(b[k*W +: W]);
      m = int'(q);
      if (s) v = (x - y + m) % m;
      else   v = (x + y) % m;
      r[k*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [L*W-1:0] splat(input int v);
    logic [L*W-1:0] r;
    for (int k = 0; k < L; k++) r[k*W +: W] = v[W-1:0];
    return r;
  endfunction

  // One cycle: drive inputs after negedge, observe, update model, advance
  task automatic step(input logic v, input logic s, input logic [L*W-1:0] d0,
                      input logic [L*W-1:0] d1, input logic [W-1:0] q,
                      input logic rdy, input logic clr);
    iValid = v; iSub = s; iData0 = d0; iData1 = d1; iQ = q; iReady = rdy; iClr = clr;
    #1;
    obsValid = oValid; obsReady = oReady; obsData = oData;
    if (clr) expQ.delete();
    else if (v && oReady) expQ.push_back(model(d0, d1, q, s));
    @(negedge iClk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, '0, '0, 8'd17, rdy, 1'b0);
  endtask

  task automatic popIfFired();
    if (obsValid && iReady && expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic test_reset();
    iRst = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b1; iSub = 1'b0;
    iData0 = '0; iData1 = '0; iQ = 8'd17;
    repeat (2) @(negedge iClk);
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", oValid); end
    checks++; if (oData !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", oData); end
    iRst = 1'b0; #1;
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", oReady); end
    @(negedge iClk);
    expQ.delete();
  endtask

  task automatic checkSingle(input string name, input logic [L*W-1:0] exp);
    idle(1'b1);
    checks++; if (obsValid !== 1'b0) begin failures++; $display("FAIL %s_lat1 got=%b exp=0", name, obsValid); end
    idle(1'b1);
    checks++; if (obsValid !== 1'b1) begin failures++; $display("FAIL %s_lat2 got=%b exp=1", name, obsValid); end
    checks++; if (obsData !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, obsData, exp); end
    popIfFired();
    idle(1'b1);
    checks++; if (obsValid !== 1'b0) begin failures++; $display("FAIL %s_oneshot got=%b exp=0", name, obsValid); end
  endtask

  task automatic test_add_boundary();
    step(1'b1, 1'b0, {8'd16, 8'd8, 8'd0, 8'd9}, {8'd1, 8'd8, 8'd0, 8'd16}, 8'd17, 1'b1, 1'b0);
    checkSingle("add_bound", {8'd0, 8'd16, 8'd0, 8'd8});
  endtask

  task automatic test_sub_boundary();
    step(1'b1, 1'b1, {8'd3, 8'd0, 8'd16, 8'd5}, {8'd5, 8'd0, 8'd0, 8'd5}, 8'd17, 1'b1, 1'b0);
    checkSingle("sub_bound", {8'd15, 8'd0, 8'd16, 8'd0});
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, splat(10), splat(10), 8'd17, 1'b1, 1'b0);
    step(1'b1, 1'b0, splat(10), splat(10), 8'd13, 1'b1, 1'b0);
    idle(1'b1);
    checks++; if (obsValid !== 1'b1 || obsData !== splat(3)) begin
      failures++; $display("FAIL b2b_first got=%b/%h exp=1/%h", obsValid, obsData, splat(3)); end
    popIfFired();
    idle(1'b1);
    checks++; if (obsValid !== 1'b1 || obsData !== splat(7)) begin
      failures++; $display("FAIL b2b_second got=%b/%h exp=1/%h", obsValid, obsData, splat(7)); end
    popIfFired();
    idle(1'b1);
    checks++; if (obsValid !== 1'b0) begin failures++; $display("FAIL b2b_tail got=%b exp=0", obsValid); end
  endtask

  task automatic test_backpressure();
    logic [L*W-1:0] a, b, prevData;
    logic [W-1:0] q;
    logic s, rdy, prevStall;
    int sent, got;
    sent = 0; got = 0; prevStall = 1'b0; prevData = '0;
    q = 8'($urandom_range(255, 2));
    for (int k = 0; k < L; k++) begin
      a[k*W +: W] = 8'($urandom_range(int'(q) - 1, 0));
      b[k*W +: W] = 8'($urandom_range(int'(q) - 1, 0));
    end
    s = 1'($urandom);
    for (int c = 0; c < 20; c++) begin
      rdy = !(c >= 3 && c <= 5);
      step(sent < 4, s, a, b, q, rdy, 1'b0);
      checks++; if (obsReady !== !(obsValid && !rdy)) begin
        failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, obsReady, !(obsValid && !rdy)); end
      if (prevStall) begin
        checks++; if (obsValid !== 1'b1 || obsData !== prevData) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, obsData, prevData); end
      end
      if (obsValid && rdy) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("FAIL bp_extra cyc=%0d got=%h", c, obsData); end
        else if (obsData !== expQ[0]) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, obsData, expQ[0]); end
        if (expQ.size() > 0) void'(expQ.pop_front());
        got++;
      end
      if (sent < 4 && obsReady) begin
        sent++;
        q = 8'($urandom_range(255, 2));
        for (int k = 0; k < L; k++) begin
          a[k*W +: W] = 8'($urandom_range(int'(q) - 1, 0));
          b[k*W +: W] = 8'($urandom_range(int'(q) - 1, 0));
        end
        s = 1'($urandom);
      end
      prevStall = obsValid && !rdy;
      prevData = obsData;
    end
    checks++; if (got != 4 || expQ.size() != 0) begin
      failures++; $display("FAIL bp_count got=%0d exp=4 left=%0d", got, expQ.size()); end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, splat(5), splat(6), 8'd17, 1'b1, 1'b0);
    step(1'b1, 1'b0, splat(7), splat(8), 8'd17, 1'b1, 1'b1);
    step(1'b1, 1'b1, splat(2), splat(9), 8'd17, 1'b1, 1'b0);
    checks++; if (obsValid !== 1'b0) begin failures++; $display("FAIL flush_drop1 got=%b exp=0", obsValid); end
    idle(1'b1);
    checks++; if (obsValid !== 1'b0) begin failures++; $display("FAIL flush_drop2 got=%b exp=0", obsValid); end
    idle(1'b1);
    checks++; if (obsValid !== 1'b1 || obsData !== splat(10)) begin
      failures++; $display("FAIL flush_after got=%b/%h exp=1/%h", obsValid, obsData, splat(10)); end
    popIfFired();
    idle(1'b1);
    checks++; if (obsValid !== 1'b0) begin failures++; $display("FAIL flush_tail got=%b exp=0", obsValid); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, splat(9), splat(4), 8'd11, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checks++; if (obsValid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", obsValid); end
    #1 iRst = 1'b1;
    #1;
    checks++; if (oValid !== 1'b0 || oData !== '0) begin
      failures++; $display("FAIL arst_clear got=%b/%h exp=0/0", oValid, oData); end
    iRst = 1'b0; #1;
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", oReady); end
    expQ.delete();
    @(negedge iClk);
    step(1'b1, 1'b1, splat(4), splat(9), 8'd11, 1'b1, 1'b0);
    checkSingle("arst_next", splat(6));
  endtask

  task automatic test_random();
    logic [L*W-1:0] a, b;
    logic [W-1:0] q;
    logic rdy;
    int c;
    for (int t = 0; t < 40; t++) begin
      q = 8'($urandom_range(255, 2));
      for (int k = 0; k < L; k++) begin
        a[k*W +: W] = 8'($urandom_range(int'(q) - 1, 0));
        b[k*W +: W] = 8'($urandom_range(int'(q) - 1, 0));
      end
      rdy = ($urandom_range(3, 0) != 0);
      step(1'($urandom), 1'($urandom), a, b, q, rdy, 1'b0);
      if (obsValid && rdy) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("FAIL rnd_extra t=%0d got=%h", t, obsData); end
        else if (obsData !== expQ[0]) begin failures++; $display("FAIL rnd_data t=%0d got=%h exp=%h", t, obsData, expQ[0]); end
        if (expQ.size() > 0) void'(expQ.pop_front());
      end
    end
    c = 0;
    while (expQ.size() > 0 && c < 10) begin
      idle(1'b1);
      if (obsValid) begin
        checks++; if (obsData !== expQ[0]) begin
          failures++; $display("FAIL rnd_drain got=%h exp=%h", obsData, expQ[0]); end
        void'(expQ.pop_front());
      end
      c++;
    end
    checks++; if (expQ.size() != 0) begin failures++; $display("FAIL rnd_timeout left=%0d exp=0", expQ.size()); end
  endtask

  initial begin
    test_reset();
    test_add_boundary();
    test_sub_boundary();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
- Multi-lane, two-stage pipelined modular adder/subtractor with a valid/ready handshake.
- Computes per lane (iData0 ± iData1) mod iQ, with add or subtract selected per transaction.
- Next generation of the single-lane registered modular adder.
- Sits in NTT/polynomial datapaths between coefficient buffers and butterfly/accumulate stages.

Parameters:
- BITWIDTH, 16, width of one coefficient and of the modulus.
- LANES, 4, number of independent parallel lanes sharing one modulus and one handshake.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  asynchronous active-high reset.
- iClr  input  1  synchronous flush: drops all in-flight transactions.
- iValid  input  1  input transaction valid.
- oReady  output  1  block can accept an input this cycle.
- iSub  input  1  0 = modular add, 1 = modular subtract (iData0 - iData1).
- iData0  input  LANES*BITWIDTH  operand A; lane k at bits [k*BITWIDTH +: BITWIDTH].
- iData1  input  LANES*BITWIDTH  operand B, same packing.
- iQ  input  BITWIDTH  modulus, sampled with each accepted transaction.
- oValid  output  1  output transaction valid.
- iReady  input  1  downstream accepts output.
- oData  output  LANES*BITWIDTH  reduced results, same packing.

Behaviour:
- Reset (iRst high, asynchronous): all stage valids = 0; oValid = 0; oData = 0; stage-1 data registers = 0. oReady is 1 as soon as iRst deasserts.
- Pipeline enable: en = ~oValid | iReady. oReady = en; the design is stall-all.
- Input accepted when iValid & oReady.
- Stage 1, on en:
  - s1_valid <= iValid.
  - Per lane, raw <= A + B (BITWIDTH+1 bits) if add, else A - B as a BITWIDTH+1 two's-complement value, MSB = borrow.
  - Registers iSub and iQ alongside the data.
- Stage 2, on en:
  - oValid <= s1_valid.
  - Add: oData lane <= (raw < Q) ? raw : raw - Q. raw == Q gives 0.
  - Subtract: oData lane <= borrow ? raw + Q (truncated to BITWIDTH) : raw.
- Latency: 2 cycles from acceptance to oValid with no stalls. Throughput: 1 transaction/cycle.
- While stalled (oValid & ~iReady): all registers hold and oData is stable. Input is not accepted.
- Bubbles: a non-valid stage-1 entry still advances on en, so bubbles collapse only at the output.
- iClr: at the next edge clears s1_valid and oValid. Data registers may hold. iClr has priority over en. oReady stays 1 in the clear cycle, but any input presented that cycle is discarded.
- iRst mid-operation: all in-flight transactions are lost; no partial output.
- Operand contract: iData0, iData1 < iQ, and iQ ≥ 2. Inputs outside the contract produce an undefined residue but must not corrupt other lanes or the handshake.
- Modulus changes: a new iQ per transaction is allowed, because Q travels with the data.
- Lane independence: no cross-lane carries.

Decomposition:
- Package mod_arith_pkg holds:
  - localparams MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
  - Default BITWIDTH and LANES.
  - A lane-slice helper macro/function.
- Sub-module mod_lane_reduce (combinational, one lane). Inputs: raw, borrow, sub, Q. Output: reduced value. Instantiated LANES times via generate.

Test Plan (BITWIDTH=8, LANES=4, Q=17 unless noted):
- Add boundary: lanes A = {16,8,0,9}, B = {1,8,0,16}, iSub=0 → after 2 cycles oData = {0,16,0,8}, oValid=1 for exactly one cycle.
- Subtract boundary: A = {3,0,16,5}, B = {5,0,0,5}, iSub=1 → oData = {15,0,16,0}.
- Back-to-back with modulus change: txn1 Q=17, A=10, B=10, add → 3; txn2 Q=13, A=10, B=10, add → 7. Both results arrive on consecutive cycles, in order.
- Backpressure: stream 4 txns with iReady low for cycles 3-5 → oReady low while oValid & ~iReady; oData held stable; no txn lost or duplicated; order preserved.
- Flush: accept 2 txns, assert iClr at the cycle the first would appear → neither txn ever shows oValid; a txn accepted the cycle after iClr emerges 2 cycles later.
- Async reset mid-stream: iRst pulse between clock edges with oValid=1 → oValid and oData = 0 immediately; oReady=1 after deassertion; next txn gives the correct result.
